// File: rtl/sha256_add_sequencer_pkg.sv
// Shared constants and types for the SHA-256 multi-operand add sequencer.
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int MAX_OPS = 5;
  localparam int CNT_W   = 3;

  localparam logic [CNT_W-1:0] MAX_CNT = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Operand counts above MAX_OPS are treated as MAX_OPS.
  function automatic logic [CNT_W-1:0] clamp_nops(input logic [CNT_W-1:0] n);
    if (n > MAX_CNT) begin
      return MAX_CNT;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/sha256_add_sequencer_if.sv
// Job request / result handshake bundle between the round-control FSM
// (master) and the add sequencer (slave).
interface sha256_add_sequencer_if;
  import sha256_pkg::*;

  logic                       i_start;
  logic [CNT_W-1:0]           i_nops;
  logic [MAX_OPS*WORD_W-1:0]  i_ops;
  logic                       o_busy;
  logic                       o_valid;
  logic                       i_ready;
  logic [WORD_W-1:0]          o_sum;
  logic                       o_ovf;

  modport master (
    output i_start, i_nops, i_ops, i_ready,
    input  o_busy, o_valid, o_sum, o_ovf
  );

  modport slave (
    input  i_start, i_nops, i_ops, i_ready,
    output o_busy, o_valid, o_sum, o_ovf
  );

endinterface

// File: rtl/sha256_add_sequencer_adder.sv
// Carry-select adder built from carry-lookahead blocks: each block computes
// its sum for both possible carry-ins and the incoming carry picks one.
module adder_csla_cla #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int NBLK = WIDTH / BLK;

  // Generate/propagate lookahead for one block; returns {carry_out, sum}.
  function automatic logic [BLK:0] cla_blk(input logic [BLK-1:0] a,
                                           input logic [BLK-1:0] b,
                                           input logic           cin);
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  logic [NBLK:0] w_c;

  assign w_c[0] = i_carry;

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    logic [BLK:0] w_r0;
    logic [BLK:0] w_r1;
    assign w_r0 = cla_blk(i_a[b*BLK +: BLK], i_b[b*BLK +: BLK], 1'b0);
    assign w_r1 = cla_blk(i_a[b*BLK +: BLK], i_b[b*BLK +: BLK], 1'b1);
    assign o_sum[b*BLK +: BLK] = w_c[b] ? w_r1[BLK-1:0] : w_r0[BLK-1:0];
    assign w_c[b+1]            = w_c[b] ? w_r1[BLK]     : w_r0[BLK];
  end

  assign o_carry = w_c[NBLK];

endmodule

// File: rtl/sha256_add_sequencer.sv
// Folds up to MAX_OPS captured 32-bit operands through one shared adder,
// one addition per clock, and returns sum and any-carry over valid/ready.
module sha256_add_sequencer
  import sha256_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  sha256_add_sequencer_if.slave     bus
);

  state_e             r_state;
  logic [WORD_W-1:0]  r_ops [MAX_OPS];
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_acc;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_idx_nxt;
  logic [WORD_W-1:0]  w_acc_nxt;
  logic               w_ovf_nxt;
  logic               w_cap;
  logic [CNT_W-1:0]   w_nops_c;
  logic [WORD_W-1:0]  w_op_sel;
  logic [WORD_W-1:0]  w_add_sum;
  logic               w_add_carry;

  assign w_nops_c = clamp_nops(bus.i_nops);

  // Select the operand addressed by the index counter.
  always_comb begin
    w_op_sel = '0;
    for (int n = 0; n < MAX_OPS; n++) begin
      if (r_idx == CNT_W'(n)) begin
        w_op_sel = r_ops[n];
      end else begin
        w_op_sel = w_op_sel;
      end
    end
  end

  adder_csla_cla #(.WIDTH(WORD_W)) u_adder (
    .i_a     (r_acc),
    .i_b     (w_op_sel),
    .i_carry (1'b0),
    .o_sum   (w_add_sum),
    .o_carry (w_add_carry)
  );

  // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_cap     = 1'b1;
          w_cnt_nxt = w_nops_c;
          w_ovf_nxt = 1'b0;
          if (w_nops_c == 3'd0) begin
            w_acc_nxt   = '0;
            w_state_nxt = DONE;
          end else if (w_nops_c == 3'd1) begin
            w_acc_nxt   = bus.i_ops[WORD_W-1:0];
            w_state_nxt = DONE;
          end else begin
            w_acc_nxt   = bus.i_ops[WORD_W-1:0];
            w_idx_nxt   = 3'd1;
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        w_acc_nxt = w_add_sum;
        w_ovf_nxt = r_ovf | w_add_carry;
        w_idx_nxt = r_idx + 3'd1;
        if (r_idx == (r_cnt - 3'd1)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DONE: begin
        if (r_valid && bus.i_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      for (int n = 0; n < MAX_OPS; n++) begin
        r_ops[n] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= (w_state_nxt == DONE);
      if (w_cap) begin
        for (int n = 0; n < MAX_OPS; n++) begin
          r_ops[n] <= bus.i_ops[n*WORD_W +: WORD_W];
        end
      end else begin
        r_ops <= r_ops;
      end
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_valid = r_valid;
  assign bus.o_sum   = r_acc;
  assign bus.o_ovf   = r_ovf;

endmodule

// File: tb/tb_sha256_add_sequencer.sv
// Directed and randomised checks of the multi-operand add sequencer.
module tb_sha256_add_sequencer;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  sha256_add_sequencer_if bus ();

  sha256_add_sequencer u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  // Issue a job at the current negedge and wait (bounded) for o_valid.
  task automatic run_job(input logic [2:0] n, input logic [159:0] ops,
                         output logic [31:0] s, output logic o, output int lat);
    bus.i_start = 1'b1;
    bus.i_nops  = n;
    bus.i_ops   = ops;
    @(negedge clk);
    bus.i_start = 1'b0;
    lat = 1;
    while (bus.o_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = bus.o_sum;
    o = bus.o_ovf;
  endtask

  initial begin
    logic [31:0]  s;
    logic         o;
    int           lat;
    logic [159:0] ops;
    logic [2:0]   n;
    int           kc;
    logic [31:0]  m_acc;
    logic         m_ovf;
    logic [32:0]  t;
    logic [159:0] five_ops;

    n_pass  = 0;
    n_total = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_nops  = 3'd0;
    bus.i_ops   = '0;
    bus.i_ready = 1'b1;
    five_ops = {32'h510e527f, 32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(bus.o_busy),  32'd0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_sum",   bus.o_sum,        32'd0);
    check("rst_ovf",   32'(bus.o_ovf),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two operands with wrap-around, step by step
    bus.i_start = 1'b1;
    bus.i_nops  = 3'd2;
    bus.i_ops   = {96'd0, 32'h00000001, 32'hFFFFFFFF};
    @(negedge clk);
    bus.i_start = 1'b0;
    check("t2_busy_c1",  32'(bus.o_busy),  32'd1);
    check("t2_valid_c1", 32'(bus.o_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_c2", 32'(bus.o_valid), 32'd1);
    check("t2_sum",      bus.o_sum,        32'h00000000);
    check("t2_ovf",      32'(bus.o_ovf),   32'd1);
    @(negedge clk);
    check("t2_busy_c3",  32'(bus.o_busy),  32'd0);
    check("t2_valid_c3", 32'(bus.o_valid), 32'd0);

    // Five SHA-256 IV words
    run_job(3'd5, five_ops, s, o, lat);
    check("t5_lat", 32'(lat), 32'd5);
    check("t5_sum", s, 32'h583ED017);
    check("t5_ovf", 32'(o), 32'd1);
    @(negedge clk);

    // Zero operands
    run_job(3'd0, five_ops, s, o, lat);
    check("t0_lat", 32'(lat), 32'd1);
    check("t0_sum", s, 32'd0);
    check("t0_ovf", 32'(o), 32'd0);
    @(negedge clk);

    // One operand
    run_job(3'd1, {128'd0, 32'h12345678}, s, o, lat);
    check("t1_lat", 32'(lat), 32'd1);
    check("t1_sum", s, 32'h12345678);
    check("t1_ovf", 32'(o), 32'd0);
    @(negedge clk);

    // Count 7 clamps to 5
    run_job(3'd7, five_ops, s, o, lat);
    check("t7_lat", 32'(lat), 32'd5);
    check("t7_sum", s, 32'h583ED017);
    check("t7_ovf", 32'(o), 32'd1);
    @(negedge clk);

    // Backpressure: result held, starts ignored, inputs changing
    bus.i_ready = 1'b0;
    run_job(3'd3, {64'd0, 32'd30, 32'd20, 32'd10}, s, o, lat);
    check("bp_lat", 32'(lat), 32'd3);
    check("bp_sum", s, 32'd60);
    for (int i = 0; i < 4; i++) begin
      bus.i_ops   = {5{32'hDEADBEEF}} ^ 160'(i);
      bus.i_nops  = 3'd2;
      bus.i_start = (i % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
      check("bp_hold_sum",   bus.o_sum,        32'd60);
      check("bp_hold_valid", 32'(bus.o_valid), 32'd1);
      check("bp_hold_ovf",   32'(bus.o_ovf),   32'd0);
    end
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("bp_after_valid", 32'(bus.o_valid), 32'd0);
    check("bp_after_busy",  32'(bus.o_busy),  32'd0);
    run_job(3'd2, {96'd0, 32'd5, 32'd7}, s, o, lat);
    check("bp_next_lat", 32'(lat), 32'd2);
    check("bp_next_sum", s, 32'd12);
    @(negedge clk);

    // Reset during accumulation
    bus.i_start = 1'b1;
    bus.i_nops  = 3'd5;
    bus.i_ops   = five_ops;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rj_busy",  32'(bus.o_busy),  32'd0);
    check("rj_valid", 32'(bus.o_valid), 32'd0);
    check("rj_sum",   bus.o_sum,        32'd0);
    run_job(3'd3, {64'd0, 32'd3, 32'd2, 32'd1}, s, o, lat);
    check("rj_fresh_lat", 32'(lat), 32'd3);
    check("rj_fresh_sum", s, 32'd6);
    check("rj_fresh_ovf", 32'(o), 32'd0);
    @(negedge clk);

    // Random regression against a 33-bit reference sum
    for (int j = 0; j < 2000; j++) begin
      ops = {$urandom, $urandom, $urandom, $urandom, $urandom};
      n   = 3'($urandom_range(0, 7));
      kc  = (int'(n) > 5) ? 5 : int'(n);
      m_acc = 32'd0;
      m_ovf = 1'b0;
      if (kc >= 1) m_acc = ops[31:0];
      for (int i = 1; i < kc; i++) begin
        t     = {1'b0, m_acc} + {1'b0, ops[i*32 +: 32]};
        m_acc = t[31:0];
        m_ovf = m_ovf | t[32];
      end
      run_job(n, ops, s, o, lat);
      check("rnd_sum", s, m_acc);
      check("rnd_ovf", 32'(o), 32'(m_ovf));
      check("rnd_lat", 32'(lat), (kc < 2) ? 32'd1 : 32'(kc));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
